// File: rtl/cpu_pkg.sv
// Shared front-end types and constants: FSM encoding, data widths, PC step
// and the word-to-byte shift helper used by the target adders.
`timescale 1ns/1ps
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned JIDX_W = 26;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_e;

  // Word offset to byte offset; the top two bits fall off, matching 32-bit wrap.
  function automatic logic [XLEN-1:0] shl2(input logic [XLEN-1:0] w);
    return {w[XLEN-3:0], 2'b00};
  endfunction

endpackage

// File: rtl/branch_target_gen.sv
// Combinational branch target: br_pc + 4 + (br_offset << 2), modulo 2^32.
`timescale 1ns/1ps
module branch_target_gen
  import cpu_pkg::*;
(
  input  logic [XLEN-1:0] br_pc_i,
  input  logic [XLEN-1:0] br_offset_i,
  output logic [XLEN-1:0] br_target_o
);

  assign br_target_o = br_pc_i + PC_STEP + shl2(br_offset_i);

endmodule

// File: rtl/pc_redirect_sequencer.sv
// Fetch PC owner: increments, stalls, takes branch/jump redirects with a 1-cycle
// latency and raises a FLUSH_CYCLES-long flush window after every redirect.
`timescale 1ns/1ps
module pc_redirect_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              fetch_ready,
  input  logic              redirect_br,
  input  logic [XLEN-1:0]   br_pc,
  input  logic [XLEN-1:0]   br_offset,
  input  logic              redirect_jmp,
  input  logic [JIDX_W-1:0] jmp_index,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus4,
  output logic              fetch_valid,
  output logic              flush
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            flush_q, flush_d;
  logic [2:0]      cnt_q, cnt_d;

  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] jmp_target;
  logic            redirect;

  branch_target_gen u_br_tgt (
    .br_pc_i     (br_pc),
    .br_offset_i (br_offset),
    .br_target_o (br_target)
  );

  assign pc_plus4   = pc_q + PC_STEP;
  assign jmp_target = {pc_plus4[31:28], jmp_index, 2'b00};
  assign redirect   = redirect_jmp | redirect_br;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    flush_d       = flush_q;
    cnt_d         = cnt_q;
    case (state_q)
      ST_IDLE: begin
        state_d       = ST_RUN;
        fetch_valid_d = 1'b1;
      end
      default: begin
        // A redirect abandons any unaccepted request, so it outranks back-pressure.
        if (redirect_jmp)                      pc_d = jmp_target;
        else if (redirect_br)                  pc_d = br_target;
        else if (stall)                        pc_d = pc_q;
        else if (fetch_valid_q && !fetch_ready) pc_d = pc_q;
        else                                   pc_d = pc_plus4;

        fetch_valid_d = !stall;

        if (redirect)          cnt_d = FLUSH_LOAD;
        else if (cnt_q != 3'd0) cnt_d = cnt_q - 3'd1;

        flush_d = (cnt_d != 3'd0);
        state_d = (cnt_d != 3'd0) ? ST_FLUSH : ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      fetch_valid_q <= 1'b0;
      flush_q       <= 1'b0;
      cnt_q         <= 3'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      flush_q       <= flush_d;
      cnt_q         <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign fetch_valid = fetch_valid_q;
  assign flush       = flush_q;

endmodule

// File: tb/tb_pc_redirect_sequencer.sv
// Randomized and directed bench for pc_redirect_sequencer against an
// event-level reference model (flush = edges since last redirect < FLUSH_CYCLES).
`timescale 1ns/1ps
module tb_pc_redirect_sequencer;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          FLUSH_N = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        fetch_ready;
  logic        redirect_br;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic        redirect_jmp;
  logic [25:0] jmp_index;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        flush;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit          m_idle;
  logic [31:0] m_pc;
  bit          m_fv;
  int          m_cyc;
  int          m_last_redir;

  pc_redirect_sequencer #(.RESET_PC(RST_PC), .FLUSH_CYCLES(FLUSH_N)) dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .fetch_ready  (fetch_ready),
    .redirect_br  (redirect_br),
    .br_pc        (br_pc),
    .br_offset    (br_offset),
    .redirect_jmp (redirect_jmp),
    .jmp_index    (jmp_index),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .flush        (flush)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_flush();
    return (m_cyc - m_last_redir) < FLUSH_N;
  endfunction

  task automatic model_reset();
    m_idle       = 1'b1;
    m_pc         = RST_PC;
    m_fv         = 1'b0;
    m_cyc        = 0;
    m_last_redir = -100;
  endtask

  task automatic clear_inputs();
    stall        = 1'b0;
    fetch_ready  = 1'b1;
    redirect_br  = 1'b0;
    redirect_jmp = 1'b0;
    br_pc        = 32'h0;
    br_offset    = 32'h0;
    jmp_index    = 26'h0;
  endtask

  // Model the edge from the inputs currently driven, clock it, then compare.
  task automatic tick();
    logic [31:0] nxt;
    if (m_idle) begin
      m_idle = 1'b0;
      m_fv   = 1'b1;
    end else begin
      nxt = m_pc;
      if (redirect_jmp)
        nxt = ((m_pc + 32'd4) & 32'hF000_0000) | ({6'b0, jmp_index} * 32'd4);
      else if (redirect_br)
        nxt = br_pc + 32'd4 + br_offset * 32'd4;
      else if (!stall && !(m_fv && !fetch_ready))
        nxt = m_pc + 32'd4;
      m_pc = nxt;
      m_fv = !stall;
      if (redirect_jmp || redirect_br) m_last_redir = m_cyc + 1;
    end
    m_cyc++;
    @(posedge clock);
    #1;
    check_eq("pc", pc, m_pc);
    check_eq("pc_plus4", pc_plus4, m_pc + 32'd4);
    check_eq("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_fv});
    check_eq("flush", {31'b0, flush}, {31'b0, exp_flush()});
  endtask

  // Asynchronous reset pulse in the middle of a cycle, checked while asserted.
  task automatic reset_pulse();
    #2 reset = 1'b1;
    #1;
    check_eq("arst_pc", pc, RST_PC);
    check_eq("arst_flush", {31'b0, flush}, 32'd0);
    check_eq("arst_fv", {31'b0, fetch_valid}, 32'd0);
    model_reset();
    #1 reset = 1'b0;
  endtask

  task automatic branch_to(input logic [31:0] target);
    clear_inputs();
    redirect_br = 1'b1;
    br_pc       = target - 32'd4;
    br_offset   = 32'd0;
    tick();
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    model_reset();
    reset = 1'b1;
    #2;
    check_eq("rst_pc", pc, RST_PC);
    check_eq("rst_fv", {31'b0, fetch_valid}, 32'd0);
    check_eq("rst_flush", {31'b0, flush}, 32'd0);
    #10 reset = 1'b0;

    // Increment sequence after leaving IDLE
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("seq_pc", pc, 32'(i * 4));
      check_eq("seq_fv", {31'b0, fetch_valid}, 32'd1);
    end

    // Negative branch offset and flush window length
    redirect_br = 1'b1; br_pc = 32'h100; br_offset = 32'hFFFF_FFFE;
    tick();
    check_eq("br_neg", pc, 32'h0000_00FC);
    check_eq("br_flush0", {31'b0, flush}, 32'd1);
    clear_inputs();
    tick();
    check_eq("br_flush1", {31'b0, flush}, 32'd1);
    tick();
    check_eq("br_flush2", {31'b0, flush}, 32'd0);

    // Jump beats branch in the same cycle
    branch_to(32'h1000_0020);
    redirect_jmp = 1'b1; jmp_index = 26'h40;
    redirect_br = 1'b1; br_pc = 32'h0000_5000; br_offset = 32'h10;
    tick();
    check_eq("jmp_wins", pc, 32'h1000_0100);
    clear_inputs();

    // Redirect wins over stall
    branch_to(32'h20);
    stall = 1'b1;
    tick();
    check_eq("stall_hold", pc, 32'h20);
    redirect_br = 1'b1; br_pc = 32'h7C; br_offset = 32'h1;
    br_pc = 32'h78;
    tick();
    check_eq("stall_redir", pc, 32'h80);
    redirect_br = 1'b0;
    tick();
    check_eq("stall_hold2", pc, 32'h80);
    check_eq("stall_fv", {31'b0, fetch_valid}, 32'd0);
    clear_inputs();
    tick();

    // Handshake back-pressure
    branch_to(32'h40);
    fetch_ready = 1'b0;
    tick();
    check_eq("bp_hold1", pc, 32'h40);
    tick();
    check_eq("bp_hold2", pc, 32'h40);
    check_eq("bp_fv", {31'b0, fetch_valid}, 32'd1);
    fetch_ready = 1'b1;
    tick();
    check_eq("bp_adv", pc, 32'h44);

    // Redirect one cycle into flush restarts the window
    branch_to(32'h200);
    redirect_br = 1'b1; br_pc = 32'h2FC;
    tick();
    clear_inputs();
    tick();
    check_eq("ext_flush1", {31'b0, flush}, 32'd1);
    tick();
    check_eq("ext_flush2", {31'b0, flush}, 32'd0);

    // Asynchronous reset in the middle of a flush window
    branch_to(32'h400);
    reset_pulse();
    tick();
    check_eq("post_rst_pc", pc, RST_PC);

    // Wrap at the top of the address space
    branch_to(32'hFFFF_FFFC);
    tick();
    check_eq("wrap", pc, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      stall        = ($urandom_range(0, 4) == 0);
      fetch_ready  = ($urandom_range(0, 3) != 0);
      redirect_br  = ($urandom_range(0, 5) == 0);
      redirect_jmp = ($urandom_range(0, 9) == 0);
      br_pc        = $urandom() & 32'hFFFF_FFFC;
      br_offset    = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($signed($urandom_range(0, 64)) - 32);
      jmp_index    = 26'($urandom());
      if ($urandom_range(0, 99) == 0) reset_pulse();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
